// File: rtl/regfile_arb_pkg.sv
// Shared constants and payload types for the regfile write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wr_hold_slot.sv
// One-entry holding slot for a writeback source. Writes to XZR complete the
// handshake but are never stored.
module wr_hold_slot
  import regfile_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  wr_req_t in_req,
  input  logic    grant,
  output logic    in_ready,
  output logic    store,
  output logic    hold_valid,
  output wr_req_t hold_req
);

  // Slot frees up in the same cycle its held write commits.
  assign in_ready = !hold_valid || grant;
  assign store    = in_valid && in_ready && (in_req.addr != XZR_ADDR);

  // Load on accept, clear when the held write commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_req   <= '0;
    end else if (store) begin
      hold_valid <= 1'b1;
      hold_req   <= in_req;
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the regfile's single write port between the ALU (slot 0) and
// load unit (slot 1). Optional round-robin: define REGFILE_WR_ARB_RR_EN.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                we3,
  output logic [ADDR_W-1:0]   wa3,
  output logic [DATA_W-1:0]   wd3,
  output logic                grant_id,
  output logic [NUM_REGS-1:0] pend_mask
);

  wr_req_t in0, in1;
  wr_req_t hold0, hold1;
  logic    valid0, valid1;
  logic    store0, store1;
  logic    grant0, grant1;
  logic    age_q;   // 1: slot 1 holds the older write
  src_e    gsel;

  assign in0 = '{addr: req0_addr, data: req0_data};
  assign in1 = '{addr: req1_addr, data: req1_data};

  wr_hold_slot u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (req0_valid),
    .in_req     (in0),
    .grant      (grant0),
    .in_ready   (req0_ready),
    .store      (store0),
    .hold_valid (valid0),
    .hold_req   (hold0)
  );

  wr_hold_slot u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (req1_valid),
    .in_req     (in1),
    .grant      (grant1),
    .in_ready   (req1_ready),
    .store      (store1),
    .hold_valid (valid1),
    .hold_req   (hold1)
  );

`ifdef REGFILE_WR_ARB_RR_EN
  logic rr_ptr_q;   // slot favoured on the next differing-address contention

  // Favour the other slot after every committed write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else if (we3) begin
      rr_ptr_q <= (gsel == SRC_ALU);
    end
  end
`endif

  // Grant select: same-address ordering by age beats priority/round-robin.
  always_comb begin
    gsel = SRC_ALU;
    if (valid0 && valid1) begin
      if (hold0.addr == hold1.addr) begin
        gsel = age_q ? SRC_MEM : SRC_ALU;
      end else begin
`ifdef REGFILE_WR_ARB_RR_EN
        gsel = rr_ptr_q ? SRC_MEM : SRC_ALU;
`else
        gsel = SRC_ALU;
`endif
      end
    end else if (valid1) begin
      gsel = SRC_MEM;
    end
  end

  // Write port driven straight from the granted slot.
  always_comb begin
    we3      = valid0 || valid1;
    grant0   = we3 && (gsel == SRC_ALU);
    grant1   = we3 && (gsel == SRC_MEM);
    grant_id = grant1;
    wa3      = '0;
    wd3      = '0;
    if (grant1) begin
      wa3 = hold1.addr;
      wd3 = hold1.data;
    end else if (grant0) begin
      wa3 = hold0.addr;
      wd3 = hold0.data;
    end
  end

  // Track which slot loaded first; a simultaneous load counts slot 1 older
  // so slot 0's value is the one that lands last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q <= 1'b0;
    end else if (store0) begin
      age_q <= 1'b1;
    end else if (store1) begin
      age_q <= 1'b0;
    end
  end

  // Pending-write mask for the hazard unit; XZR is never held.
  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_mask[r] = (valid0 && (hold0.addr == ADDR_W'(r))) ||
                     (valid1 && (hold1.addr == ADDR_W'(r)));
    end
    pend_mask[XZR_ADDR] = 1'b0;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port (we3/wa3/wd3) between two writeback sources: requester 0 (ALU writeback) and requester 1 (load/memory unit). Each requester has a one-entry holding slot with a valid/ready handshake. The arbiter drives the regfile write port, drops writes to X31 (XZR) and exports a pending-write mask to the hazard unit.

Parameters:
DATA_W, 64, write data width (matches regfile wd3)
ADDR_W, 5, register address width (32 registers, X31 = XZR)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 (ALU) has a write
req0_ready  out  1  requester 0 slot can accept
req0_addr  in  ADDR_W  destination register
req0_data  in  DATA_W  write value
req1_valid  in  1  requester 1 (load unit) has a write
req1_ready  out  1  requester 1 slot can accept
req1_addr  in  ADDR_W  destination register
req1_data  in  DATA_W  write value
we3  out  1  regfile write enable
wa3  out  ADDR_W  regfile write address
wd3  out  DATA_W  regfile write data
grant_id  out  1  source of the current write (0/1); valid only when we3=1
pend_mask  out  32  bit r=1 while a held write targets register r

Behaviour:
- Reset (async, takes effect immediately): both slots invalid, age bit=0, RR pointer=0. Outputs: we3=0, wa3=0, wd3=0, grant_id=0, pend_mask=0, req0_ready=1, req1_ready=1. Reset mid-operation discards held writes.
- Slot n: hold_valid, hold_addr, hold_data. reqn_ready = !hold_valid OR (slot n granted this cycle). Accept on posedge when reqn_valid & reqn_ready.
- XZR: a request with addr=31 is accepted per normal handshake but never stored. The slot stays or becomes empty and no write is issued. pend_mask[31] is always 0.
- Write port is combinational from the slots. we3=1 when any slot is valid. wa3/wd3 come from the granted slot and are 0 when we3=0. The write commits at the next posedge, where the granted slot clears (or reloads on a same-cycle accept).
- Latency: a request accepted at edge k is written at edge k+1 if granted. A stalled slot keeps we3 asserted.
- Grant, fixed priority (default): slot 0 wins when both slots are valid.
- Same-address rule, overrides priority: if both slots are valid with equal hold_addr, the older slot is granted first.
  - Age bit records which slot loaded first.
  - If both slots loaded on the same edge, slot 1 is treated as older, so slot 0's value ends up final.
- Throughput: one regfile write per cycle, with back-to-back acceptance into a slot.
- pend_mask[r] = OR over slots of (hold_valid & hold_addr==r). Purely combinational.
- Known limitation without RR: continuous req0 traffic starves slot 1.

Optional Feature:
REGFILE_WR_ARB_RR_EN
- Defined: round-robin between slots when both are valid and addresses differ. A 1-bit pointer names the slot to favour and flips to the other slot after each grant. The same-address age rule still overrides the pointer.
- Undefined: fixed priority (slot 0). No pointer flop exists.

Decomposition:
- Package regfile_arb_pkg contains:
  - constants DATA_W=64, ADDR_W=5, XZR_ADDR=5'd31
  - typedef wr_req_t {addr, data}
  - typedef src_e {SRC_ALU=0, SRC_MEM=1}
- Sub-module wr_hold_slot: one-entry holding register with valid/ready, XZR drop, load/clear. Instantiated twice. Arbitration, age and pend_mask logic stay in the top.

Test Plan:
- Single write: req0 addr=1, data=200 for one cycle. Expect we3=1, wa3=1, wd3=200 the following cycle. Regfile X1 reads 200; pend_mask=0x2 for exactly one cycle.
- Contention: req0 (addr=5, data=10) and req1 (addr=10, data=111) in the same cycle. Fixed priority writes X5 first, X10 next cycle; req1_ready=0 during its stall. With RR_EN and pointer=1, X10 is written first.
- Same address: same-cycle req0 (addr=3, data=7) and req1 (addr=3, data=9). Writes occur in order 9 then 7, and X3 finally holds 7. Also: req1 (addr=3) loaded one cycle before req0 (addr=3) under fixed priority, so slot 1 writes first.
- XZR drop: req1 addr=31, data=999. req1_ready=1, we3 never asserted, pend_mask=0. X31 still reads 0.
- Back-to-back: req0 valid for 8 consecutive cycles (addr=i, data=i+100). Expect 8 writes on 8 consecutive cycles with req0_ready held at 1. Under fixed priority with req1 also valid, req1 never completes; with RR_EN, grants alternate.
- Async reset mid-stall: both slots full, assert reset between edges. we3, pend_mask and grant_id drop to 0 immediately and no write occurs at the next edge. After release, both ready=1.
